// File: rtl/mcu_pkg.sv
// Shared MCU datapath constants: default widths and N/Z/P condition-code encodings.
package mcu_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 3;

  // One-hot condition codes, ordered {N,Z,P}
  localparam logic [2:0] CC_N     = 3'b100;
  localparam logic [2:0] CC_Z     = 3'b010;
  localparam logic [2:0] CC_P     = 3'b001;
  localparam logic [2:0] CC_RESET = CC_Z;

endpackage

// File: rtl/cc_gen.sv
// Condition-code generator: classifies a value as negative, zero or positive.
// Shared with the ALU flag path, so it stays purely combinational.
module cc_gen
  import mcu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] din,
  output logic [2:0]        nzp
);

  // Sign bit takes precedence; zero check only matters for non-negative values
  always_comb begin
    nzp = CC_P;
    if (din[DATA_W-1])  nzp = CC_N;
    else if (din == '0) nzp = CC_Z;
  end

endmodule

// File: rtl/regfile_2r1w.sv
// 2-read/1-write register file with registered reads, write-to-read forwarding,
// per-register busy scoreboard, N/Z/P flags and a sticky bad-index flag.
module regfile_2r1w
  import mcu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NREGS  = 2**ADDR_W
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [ADDR_W-1:0] SR1,
  input  logic [ADDR_W-1:0] SR2,
  input  logic              RDEN,
  input  logic [ADDR_W-1:0] DR,
  input  logic              LDREG,
  input  logic [DATA_W-1:0] DIN,
  input  logic              LOCK,
  input  logic [ADDR_W-1:0] LOCKDR,
  output logic [DATA_W-1:0] SR1OUT,
  output logic [DATA_W-1:0] SR2OUT,
  output logic              RVALID,
  output logic              BUSY1,
  output logic              BUSY2,
  output logic [2:0]        NZP,
  output logic              ADDR_ERR
);

  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  busy, busy_nxt;
  logic [DATA_W-1:0] rd1, rd2;
  logic [2:0]        din_cc;
  logic              sr1_ok, sr2_ok, dr_ok, lk_ok, wr_ok, lk_set, bad_idx;

  function automatic logic in_rng(input logic [ADDR_W-1:0] idx);
    return 32'(idx) < 32'(NREGS);
  endfunction

  assign sr1_ok  = in_rng(SR1);
  assign sr2_ok  = in_rng(SR2);
  assign dr_ok   = in_rng(DR);
  assign lk_ok   = in_rng(LOCKDR);
  assign wr_ok   = LDREG && dr_ok;
  assign lk_set  = LOCK && lk_ok;
  assign bad_idx = (RDEN && (!sr1_ok || !sr2_ok)) || (LDREG && !dr_ok) || (LOCK && !lk_ok);

  cc_gen #(.DATA_W(DATA_W)) u_cc (.din(DIN), .nzp(din_cc));

  // Read-port muxes: out-of-range reads give 0, same-cycle write to the index is forwarded
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (sr1_ok) rd1 = (wr_ok && SR1 == DR) ? DIN : regs[SR1];
    if (sr2_ok) rd2 = (wr_ok && SR2 == DR) ? DIN : regs[SR2];
  end

  // Scoreboard next state: clear on write first, then lock so a same-index lock wins
  always_comb begin
    busy_nxt = busy;
    if (wr_ok)  busy_nxt[DR]     = 1'b0;
    if (lk_set) busy_nxt[LOCKDR] = 1'b1;
  end

  // Storage array
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[DR] <= DIN;
    end
  end

  // Registered read outputs; data holds when no read is issued
  always_ff @(posedge CLK) begin
    if (RESET) begin
      SR1OUT <= '0;
      SR2OUT <= '0;
      RVALID <= 1'b0;
    end else begin
      RVALID <= RDEN;
      if (RDEN) begin
        SR1OUT <= rd1;
        SR2OUT <= rd2;
      end
    end
  end

  // Busy bits, condition codes and sticky index error
  always_ff @(posedge CLK) begin
    if (RESET) begin
      busy     <= '0;
      NZP      <= CC_RESET;
      ADDR_ERR <= 1'b0;
    end else begin
      busy <= busy_nxt;
      if (wr_ok)   NZP      <= din_cc;
      if (bad_idx) ADDR_ERR <= 1'b1;
    end
  end

  assign BUSY1 = sr1_ok && busy[SR1];
  assign BUSY2 = sr2_ok && busy[SR2];

endmodule

// File: tb/tb_regfile_2r1w.sv
// Bench for regfile_2r1w: full-size instance checked against a behavioural model
// with a read-data scoreboard, plus a 6-register instance for bad-index handling.
module tb_regfile_2r1w;

  logic        CLK = 1'b0;
  logic        RESET, RDEN, LDREG, LOCK;
  logic [2:0]  SR1, SR2, DR, LOCKDR;
  logic [15:0] DIN;
  logic [15:0] SR1OUT, SR2OUT;
  logic        RVALID, BUSY1, BUSY2, ADDR_ERR;
  logic [2:0]  NZP;

  logic        b_reset, b_rden, b_ldreg, b_lock;
  logic [2:0]  b_sr1, b_sr2, b_dr, b_lockdr;
  logic [15:0] b_din, b_sr1out, b_sr2out;
  logic        b_rvalid, b_busy1, b_busy2, b_addr_err;
  logic [2:0]  b_nzp;

  int n_chk  = 0;
  int n_pass = 0;

  // model state
  logic [15:0] m_regs [8];
  logic [7:0]  m_busy;
  logic [2:0]  m_nzp;
  logic        m_rv;
  logic [31:0] m_last;
  logic [31:0] sb_q [$];

  always #5 CLK = ~CLK;

  regfile_2r1w #(.DATA_W(16), .ADDR_W(3), .NREGS(8)) dut (
    .CLK(CLK), .RESET(RESET), .SR1(SR1), .SR2(SR2), .RDEN(RDEN), .DR(DR),
    .LDREG(LDREG), .DIN(DIN), .LOCK(LOCK), .LOCKDR(LOCKDR), .SR1OUT(SR1OUT),
    .SR2OUT(SR2OUT), .RVALID(RVALID), .BUSY1(BUSY1), .BUSY2(BUSY2), .NZP(NZP),
    .ADDR_ERR(ADDR_ERR)
  );

  regfile_2r1w #(.DATA_W(16), .ADDR_W(3), .NREGS(6)) dut6 (
    .CLK(CLK), .RESET(b_reset), .SR1(b_sr1), .SR2(b_sr2), .RDEN(b_rden), .DR(b_dr),
    .LDREG(b_ldreg), .DIN(b_din), .LOCK(b_lock), .LOCKDR(b_lockdr), .SR1OUT(b_sr1out),
    .SR2OUT(b_sr2out), .RVALID(b_rvalid), .BUSY1(b_busy1), .BUSY2(b_busy2), .NZP(b_nzp),
    .ADDR_ERR(b_addr_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic drv(input logic rst, input logic rden, input int s1, input int s2,
                     input logic ld, input int d, input logic [15:0] di,
                     input logic lk, input int lkd);
    RESET = rst; RDEN = rden; SR1 = 3'(s1); SR2 = 3'(s2);
    LDREG = ld; DR = 3'(d); DIN = di; LOCK = lk; LOCKDR = 3'(lkd);
  endtask

  // One cycle on the main instance: busy check before the edge, model update
  // at the edge, registered outputs checked on the following falling edge.
  task automatic tick();
    logic [15:0] e1, e2;
    logic [31:0] ex;
    #1;
    if (!RESET) begin
      chk("busy1", 32'(BUSY1), 32'(m_busy[SR1]));
      chk("busy2", 32'(BUSY2), 32'(m_busy[SR2]));
      if (RDEN) begin
        e1 = (LDREG && DR == SR1) ? DIN : m_regs[SR1];
        e2 = (LDREG && DR == SR2) ? DIN : m_regs[SR2];
        sb_q.push_back({e1, e2});
      end
    end
    @(posedge CLK);
    if (RESET) begin
      for (int i = 0; i < 8; i++) m_regs[i] = '0;
      m_busy = '0; m_nzp = 3'b010; m_rv = 1'b0; m_last = '0;
    end else begin
      if (LDREG) begin
        m_regs[DR] = DIN;
        m_nzp = DIN[15] ? 3'b100 : (DIN == 16'h0) ? 3'b010 : 3'b001;
        m_busy[DR] = 1'b0;
      end
      if (LOCK) m_busy[LOCKDR] = 1'b1;
      m_rv = RDEN;
    end
    @(negedge CLK);
    chk("rvalid", 32'(RVALID), 32'(m_rv));
    if (m_rv) begin
      if (sb_q.size() == 0) chk("sb_empty", 32'd1, 32'd0);
      else begin
        ex = sb_q.pop_front();
        m_last = ex;
        chk("sr1out", 32'(SR1OUT), 32'(ex[31:16]));
        chk("sr2out", 32'(SR2OUT), 32'(ex[15:0]));
      end
    end else begin
      chk("hold1", 32'(SR1OUT), 32'(m_last[31:16]));
      chk("hold2", 32'(SR2OUT), 32'(m_last[15:0]));
    end
    chk("nzp", 32'(NZP), 32'(m_nzp));
    chk("addr_err", 32'(ADDR_ERR), 32'd0);
  endtask

  task automatic btick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    m_busy = '0; m_nzp = 3'b010; m_rv = 1'b0; m_last = '0;
    b_reset = 1'b1; b_rden = 0; b_ldreg = 0; b_lock = 0;
    b_sr1 = 0; b_sr2 = 0; b_dr = 0; b_lockdr = 0; b_din = '0;

    drv(1, 0, 0, 0, 0, 0, 16'h0, 0, 0); tick(); tick();
    // read after reset
    drv(0, 1, 3, 5, 0, 0, 16'h0, 0, 0); tick();
    chk("tp_rst_sr1", 32'(SR1OUT), 32'h0);
    chk("tp_rst_nzp", 32'(NZP), 32'h2);
    // write negative then read it back
    drv(0, 0, 0, 0, 1, 2, 16'h8001, 0, 0); tick();
    chk("tp_nzp_n", 32'(NZP), 32'h4);
    drv(0, 1, 2, 0, 0, 0, 16'h0, 0, 0); tick();
    chk("tp_rd_r2", 32'(SR1OUT), 32'h8001);
    // forwarding to both ports
    drv(0, 1, 4, 4, 1, 4, 16'h0007, 0, 0); tick();
    chk("tp_fwd1", 32'(SR1OUT), 32'h0007);
    chk("tp_fwd2", 32'(SR2OUT), 32'h0007);
    chk("tp_nzp_p", 32'(NZP), 32'h1);
    drv(0, 0, 4, 2, 0, 0, 16'h0, 0, 0); tick();
    // scoreboard: lock, lock+write same index, then plain write clears
    drv(0, 0, 6, 0, 0, 0, 16'h0, 1, 6); tick();
    drv(0, 0, 6, 0, 1, 6, 16'h0055, 1, 6); tick();
    drv(0, 0, 6, 0, 1, 6, 16'h0066, 0, 0); tick();
    drv(0, 1, 6, 6, 0, 0, 16'h0, 0, 0); tick();
    chk("tp_busy_clr", 32'(BUSY1), 32'd0);
    // zero flag, then reset overriding a read and write
    drv(0, 0, 0, 0, 1, 1, 16'h0000, 0, 0); tick();
    drv(1, 1, 1, 1, 1, 1, 16'hFFFF, 1, 3); tick();
    chk("tp_rst_rv", 32'(RVALID), 32'd0);
    drv(0, 1, 1, 2, 0, 0, 16'h0, 0, 0); tick();
    chk("tp_rst_r1", 32'(SR1OUT), 32'h0);
    // randomized traffic
    for (int k = 0; k < 60; k++) begin
      drv(0, 1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 7),
          1'($urandom_range(0, 1)), $urandom_range(0, 7),
          ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom),
          1'($urandom_range(0, 3) == 0), $urandom_range(0, 7));
      tick();
    end
    drv(0, 0, 0, 0, 0, 0, 16'h0, 0, 0);

    // 6-register instance: out-of-range indices
    btick();
    chk("b_rst_err", 32'(b_addr_err), 32'd0);
    chk("b_rst_nzp", 32'(b_nzp), 32'h2);
    b_reset = 0; b_ldreg = 1; b_dr = 3'd7; b_din = 16'h1234; btick();
    chk("b_err_wr", 32'(b_addr_err), 32'd1);
    chk("b_nzp_ign", 32'(b_nzp), 32'h2);
    b_dr = 3'd5; b_din = 16'h0042; btick();
    chk("b_err_sticky", 32'(b_addr_err), 32'd1);
    chk("b_nzp_p", 32'(b_nzp), 32'h1);
    b_ldreg = 0; b_rden = 1; b_sr1 = 3'd7; b_sr2 = 3'd5;
    b_lock = 1; b_lockdr = 3'd6; btick();
    chk("b_rd_oor", 32'(b_sr1out), 32'h0);
    chk("b_rd_r5", 32'(b_sr2out), 32'h0042);
    chk("b_rvalid", 32'(b_rvalid), 32'd1);
    b_rden = 0; b_lock = 0; b_sr1 = 3'd6; #1;
    chk("b_busy_oor", 32'(b_busy1), 32'd0);
    b_reset = 1; btick();
    chk("b_err_clr", 32'(b_addr_err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/regfile_2r1w.md
Name: regfile_2r1w

Overview:
Parametrised general-purpose register file for the MCU datapath: 2 read ports (SR1/SR2), 1 write port (DR).
- Registered reads with write-to-read forwarding.
- Per-register busy scoreboard for the control FSM.
- N/Z/P condition codes updated on every register write.
- Sits between the decode/control unit and the ALU; stores registers locally instead of routing through the memory module.

Parameters:
DATA_W, 16, register width in bits
ADDR_W, 3, register index width
NREGS, 2**ADDR_W, number of registers (must be <= 2**ADDR_W)

Ports:
CLK  input  1  clock, all state updates on rising edge
RESET  input  1  synchronous, active-high reset
SR1  input  ADDR_W  read port 1 register index
SR2  input  ADDR_W  read port 2 register index
RDEN  input  1  read enable; when 1, both read outputs are captured this cycle
DR  input  ADDR_W  write register index
LDREG  input  1  write enable for DR
DIN  input  DATA_W  write data
LOCK  input  1  mark register LOCKDR busy (result outstanding)
LOCKDR  input  ADDR_W  register index to lock
SR1OUT  output  DATA_W  registered read data, port 1
SR2OUT  output  DATA_W  registered read data, port 2
RVALID  output  1  SR1OUT/SR2OUT updated from a read issued the previous cycle
BUSY1  output  1  combinational: register SR1 currently locked
BUSY2  output  1  combinational: register SR2 currently locked
NZP  output  3  condition codes {N,Z,P} of last written value
ADDR_ERR  output  1  sticky: an index >= NREGS was used

Behaviour:
- Reset (RESET=1 at a rising CLK edge):
  - All registers 0; SR1OUT=SR2OUT=0; RVALID=0; busy bits all 0; NZP=3'b010; ADDR_ERR=0.
  - Reset has priority over every other input in that cycle and aborts any in-flight read (RVALID=0 next cycle).
- Write:
  - LDREG=1 and DR<NREGS: reg[DR] <= DIN at the edge.
  - The same edge updates NZP from DIN: N=DIN[DATA_W-1]; Z=(DIN==0); P=otherwise.
  - Exactly one NZP bit is ever set.
- Read:
  - RDEN=1: SR1OUT <= reg[SR1], SR2OUT <= reg[SR2]; RVALID <= 1. Latency 1 cycle.
  - RDEN=0: outputs hold their previous value; RVALID <= 0.
- Forwarding: if RDEN and LDREG are both 1 and SRx==DR (valid index), SRxOUT captures DIN, not the old reg value. Applies independently to each port; SR1==SR2==DR forwards to both.
- Scoreboard:
  - LOCK=1 sets busy[LOCKDR].
  - LDREG=1 clears busy[DR].
  - Same cycle, same index: lock wins (busy stays 1). This models back-to-back producers.
  - BUSY1/BUSY2 reflect current busy bits; no forwarding of same-cycle LOCK/LDREG effects.
- Out of range index (any of SR1, SR2, DR, LOCKDR >= NREGS while its enable is active):
  - Writes are ignored; reads return 0; lock is ignored.
  - ADDR_ERR <= 1 and stays set until RESET.
  - Never raised when NREGS == 2**ADDR_W.
- Width rules: DIN stored unmodified, no extension inside the block. Any sign/zero extension is done by the caller.
- No combinational path from DIN to SR1OUT/SR2OUT; only BUSY1/BUSY2 are combinational (from SR1/SR2 and the busy register).

Decomposition:
- Shared package mcu_pkg:
  - DATA_W/ADDR_W defaults.
  - NZP encodings: CC_N=3'b100, CC_Z=3'b010, CC_P=3'b001.
  - Reset value CC_RESET=CC_Z.
- One sub-module: cc_gen (combinational, DATA_W parameter, DIN -> 3-bit NZP). It is reused by the ALU flag path.
- Storage array, forwarding mux and scoreboard stay in regfile_2r1w.

Test Plan:
- Reset then RDEN=1, SR1=3, SR2=5 -> next cycle SR1OUT=0, SR2OUT=0, RVALID=1, NZP=010, BUSY1=BUSY2=0.
- LDREG=1, DR=2, DIN=16'h8001; next cycle RDEN=1, SR1=2 -> SR1OUT=16'h8001 one cycle later, NZP=100.
- Same cycle LDREG=1, DR=4, DIN=16'h0007, RDEN=1, SR1=4, SR2=4 -> next cycle SR1OUT=SR2OUT=16'h0007, NZP=001 (forwarding both ports).
- LOCK=1, LOCKDR=6 -> BUSY1=1 when SR1=6; then LDREG=1, DR=6, LOCK=1, LOCKDR=6 same cycle -> busy stays 1; next LDREG to R6 without LOCK -> BUSY1=0.
- Write DIN=0 to R1 -> NZP=010; assert RESET during a cycle with RDEN=1, LDREG=1, DR=1, DIN=16'hFFFF -> R1 stays 0, RVALID=0, NZP=010.
- NREGS=6 build: LDREG=1, DR=7, DIN=16'h1234 -> no register changes, ADDR_ERR=1 sticky; RDEN with SR1=7 -> SR1OUT=0.
